// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs mult/div on a countdown and raises the D-stage stall.
// Optional MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7..10) as multi-cycle accumulate ops.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_use_D,
   output logic        busy,
   output logic        start,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [31:0]      hi_q, lo_q, hi_next, lo_next;
   logic [31:0]      shadow_hi, shadow_lo, shadow_hi_next, shadow_lo_next;
   logic             shadow_wr, shadow_wr_next;

   logic             is_mult, is_div;
   logic [63:0]      prod_s, prod_u;
   logic [31:0]      abs_a, abs_b, q_mag, r_mag, quot_s, rem_s;
   logic [31:0]      res_hi, res_lo;
   logic             res_wr;

   always_comb begin
      is_mult = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
`ifdef MDU_MADD_EN
      is_mult = is_mult || (md_op_E == OP_MADD) || (md_op_E == OP_MADDU) ||
                (md_op_E == OP_MSUB) || (md_op_E == OP_MSUBU);
`endif
      is_div = (md_op_E == OP_DIV) || (md_op_E == OP_DIVU);
   end

   assign busy  = (state == RUN);
   assign start = (is_mult || is_div) && (state == IDLE);
   assign stall = md_use_D && (busy || start);
   assign HI    = hi_q;
   assign LO    = lo_q;

   // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
   always_comb begin
      prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
      prod_u = {32'd0, rs_E} * {32'd0, rt_E};
      abs_a  = rs_E[31] ? (32'd0 - rs_E) : rs_E;
      abs_b  = rt_E[31] ? (32'd0 - rt_E) : rt_E;
      q_mag  = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
      r_mag  = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
      quot_s = (rs_E[31] ^ rt_E[31]) ? (32'd0 - q_mag) : q_mag;
      rem_s  = rs_E[31] ? (32'd0 - r_mag) : r_mag;
   end

   // Result computed at the start edge; a zero divisor leaves HI/LO untouched at completion.
   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      res_wr = 1'b1;
      case (md_op_E)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            if (rt_E == 32'd0) res_wr = 1'b0;
            else begin
               res_lo = quot_s;
               res_hi = rem_s;
            end
         end
         OP_DIVU: begin
            if (rt_E == 32'd0) res_wr = 1'b0;
            else begin
               res_lo = rs_E / rt_E;
               res_hi = rs_E % rt_E;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
         OP_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
         OP_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
         OP_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
         default:  res_wr = 1'b0;
      endcase
   end

   // Next-state: HI/LO only change on mthi/mtlo in IDLE or at the completion edge of RUN.
   always_comb begin
      state_next     = state;
      count_next     = count;
      hi_next        = hi_q;
      lo_next        = lo_q;
      shadow_hi_next = shadow_hi;
      shadow_lo_next = shadow_lo;
      shadow_wr_next = shadow_wr;
      case (state)
         IDLE: begin
            if (start) begin
               state_next     = RUN;
               count_next     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               shadow_hi_next = res_hi;
               shadow_lo_next = res_lo;
               shadow_wr_next = res_wr;
            end else if (md_op_E == OP_MTHI) begin
               hi_next = rs_E;
            end else if (md_op_E == OP_MTLO) begin
               lo_next = rs_E;
            end
         end
         RUN: begin
            count_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               state_next = IDLE;
               count_next = '0;
               if (shadow_wr) begin
                  hi_next = shadow_hi;
                  lo_next = shadow_lo;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         shadow_hi <= '0;
         shadow_lo <= '0;
         shadow_wr <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         hi_q      <= hi_next;
         lo_q      <= lo_next;
         shadow_hi <= shadow_hi_next;
         shadow_lo <= shadow_lo_next;
         shadow_wr <= shadow_wr_next;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; madd expectations follow MDU_MADD_EN.
module tb_mdu_ctrl;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  md_op_E;
   logic [31:0] rs_E, rt_E;
   logic        md_use_D;
   logic        busy, start, stall;
   logic [31:0] HI, LO;

   int n_checks = 0;
   int n_fail   = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .md_op_E(md_op_E), .rs_E(rs_E), .rt_E(rt_E),
      .md_use_D(md_use_D), .busy(busy), .start(start), .stall(stall), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Presents an op for one start edge, then counts busy cycles until completion (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
      md_op_E = op; rs_E = a; rt_E = b;
      step();
      md_op_E = OP_NONE;
      cycles = 0;
      while (busy === 1'b1 && cycles < 50) begin
         cycles++;
         step();
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; md_op_E = OP_NONE; rs_E = '0; rt_E = '0; md_use_D = 1'b1;
      step(); step();
      reset = 1'b1;
      step();
      n_checks++; if (HI !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hi: got %h expected %h", HI, 32'd0); end
      n_checks++; if (LO !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_lo: got %h expected %h", LO, 32'd0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
      md_use_D = 1'b0;
   endtask

   task automatic test_mult;
      int cycles;
      md_op_E = OP_MULT; rs_E = 32'hFFFFFFFE; rt_E = 32'd3;
      #1;
      n_checks++; if (start !== 1'b1) begin n_fail++; $display("[TB] FAIL mult_start: got %b expected 1", start); end
      step();
      md_op_E = OP_NONE;
      n_checks++; if (HI !== 32'd0) begin n_fail++; $display("[TB] FAIL mult_hi_during_run: got %h expected %h", HI, 32'd0); end
      cycles = 0;
      while (busy === 1'b1 && cycles < 50) begin
         cycles++;
         step();
      end
      n_checks++; if (cycles != 5) begin n_fail++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 5", cycles); end
      n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL mult_hi: got %h expected %h", HI, 32'hFFFFFFFF); end
      n_checks++; if (LO !== 32'hFFFFFFFA) begin n_fail++; $display("[TB] FAIL mult_lo: got %h expected %h", LO, 32'hFFFFFFFA); end
      run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, cycles);
      n_checks++; if (cycles != 5) begin n_fail++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 5", cycles); end
      n_checks++; if (HI !== 32'h00000002) begin n_fail++; $display("[TB] FAIL multu_hi: got %h expected %h", HI, 32'h2); end
      n_checks++; if (LO !== 32'hFFFFFFFA) begin n_fail++; $display("[TB] FAIL multu_lo: got %h expected %h", LO, 32'hFFFFFFFA); end
   endtask

   task automatic test_div;
      int cycles;
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cycles);
      n_checks++; if (cycles != 10) begin n_fail++; $display("[TB] FAIL div_busy_cycles: got %0d expected 10", cycles); end
      n_checks++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL div_lo: got %h expected %h", LO, 32'hFFFFFFFD); end
      n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL div_hi: got %h expected %h", HI, 32'hFFFFFFFF); end
      run_op(OP_DIVU, 32'd7, 32'd0, cycles);
      n_checks++; if (cycles != 10) begin n_fail++; $display("[TB] FAIL divz_busy_cycles: got %0d expected 10", cycles); end
      n_checks++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL divz_lo: got %h expected %h", LO, 32'hFFFFFFFD); end
      n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL divz_hi: got %h expected %h", HI, 32'hFFFFFFFF); end
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cycles);
      n_checks++; if (LO !== 32'h80000000) begin n_fail++; $display("[TB] FAIL div_ovf_lo: got %h expected %h", LO, 32'h80000000); end
      n_checks++; if (HI !== 32'd0) begin n_fail++; $display("[TB] FAIL div_ovf_hi: got %h expected %h", HI, 32'd0); end
   endtask

   // div 100/7 with md_use_D held high; an mtlo and a mult arrive mid-run and must be dropped.
   task automatic test_stall;
      int cycles;
      md_use_D = 1'b1; md_op_E = OP_DIV; rs_E = 32'd100; rt_E = 32'd7;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_start: got %b expected 1", stall); end
      step();
      md_op_E = OP_NONE;
      cycles = 0;
      while (busy === 1'b1 && cycles < 50) begin
         cycles++;
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_busy: cycle %0d got %b expected 1", cycles, stall); end
         if (cycles == 3) begin md_op_E = OP_MTLO; rs_E = 32'h1234; end
         else if (cycles == 5) begin md_op_E = OP_MULT; rs_E = 32'd2; rt_E = 32'd2; end
         else md_op_E = OP_NONE;
         step();
      end
      n_checks++; if (cycles != 10) begin n_fail++; $display("[TB] FAIL stall_busy_cycles: got %0d expected 10", cycles); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_done: got %b expected 0", stall); end
      n_checks++; if (LO !== 32'd14) begin n_fail++; $display("[TB] FAIL stall_div_lo: got %h expected %h", LO, 32'd14); end
      n_checks++; if (HI !== 32'd2) begin n_fail++; $display("[TB] FAIL stall_div_hi: got %h expected %h", HI, 32'd2); end
      md_use_D = 1'b0;
   endtask

   task automatic test_back_to_back;
      int cycles;
      md_op_E = OP_MTHI; rs_E = 32'hDEADBEEF;
      #1;
      n_checks++; if (start !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi_start: got %b expected 0", start); end
      step();
      md_op_E = OP_NONE;
      n_checks++; if (HI !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL mthi_hi: got %h expected %h", HI, 32'hDEADBEEF); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi_busy: got %b expected 0", busy); end
      n_checks++; if (LO !== 32'd14) begin n_fail++; $display("[TB] FAIL mthi_lo_kept: got %h expected %h", LO, 32'd14); end
      run_op(OP_MULT, 32'd3, 32'd4, cycles);
      n_checks++; if (LO !== 32'd12 || HI !== 32'd0) begin n_fail++; $display("[TB] FAIL b2b_first: got %h_%h expected %h_%h", HI, LO, 32'd0, 32'd12); end
      md_op_E = OP_MULTU; rs_E = 32'd5; rt_E = 32'd6;
      #1;
      n_checks++; if (start !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_start: got %b expected 1", start); end
      step();
      md_op_E = OP_NONE;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
      cycles = 0;
      while (busy === 1'b1 && cycles < 50) begin
         cycles++;
         step();
      end
      n_checks++; if (cycles != 5) begin n_fail++; $display("[TB] FAIL b2b_cycles: got %0d expected 5", cycles); end
      n_checks++; if (LO !== 32'd30 || HI !== 32'd0) begin n_fail++; $display("[TB] FAIL b2b_second: got %h_%h expected %h_%h", HI, LO, 32'd0, 32'd30); end
   endtask

   task automatic test_madd;
      int cycles;
      md_op_E = OP_MTHI; rs_E = 32'd0;
      step();
      md_op_E = OP_MTLO; rs_E = 32'hFFFFFFFF;
      step();
      md_use_D = 1'b1; md_op_E = OP_MADDU; rs_E = 32'd1; rt_E = 32'd1;
      #1;
`ifdef MDU_MADD_EN
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL madd_stall: got %b expected 1", stall); end
      md_use_D = 1'b0;
      run_op(OP_MADDU, 32'd1, 32'd1, cycles);
      n_checks++; if (cycles != 5) begin n_fail++; $display("[TB] FAIL madd_cycles: got %0d expected 5", cycles); end
      n_checks++; if (HI !== 32'd1) begin n_fail++; $display("[TB] FAIL madd_hi: got %h expected %h", HI, 32'd1); end
      n_checks++; if (LO !== 32'd0) begin n_fail++; $display("[TB] FAIL madd_lo: got %h expected %h", LO, 32'd0); end
`else
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL madd_stall: got %b expected 0", stall); end
      md_use_D = 1'b0;
      run_op(OP_MADDU, 32'd1, 32'd1, cycles);
      n_checks++; if (cycles != 0) begin n_fail++; $display("[TB] FAIL madd_cycles: got %0d expected 0", cycles); end
      repeat (6) step();
      n_checks++; if (HI !== 32'd0) begin n_fail++; $display("[TB] FAIL madd_hi: got %h expected %h", HI, 32'd0); end
      n_checks++; if (LO !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL madd_lo: got %h expected %h", LO, 32'hFFFFFFFF); end
`endif
   endtask

   task automatic test_reset_mid_run;
      md_op_E = OP_MTHI; rs_E = 32'h55AA55AA;
      step();
      md_op_E = OP_MULT; rs_E = 32'd7; rt_E = 32'd9;
      step();
      md_op_E = OP_NONE;
      step();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_running: got %b expected 1", busy); end
      reset = 1'b0;
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++; if (HI !== 32'd0 || LO !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_clear: got %h_%h expected 0_0", HI, LO); end
      reset = 1'b1;
      repeat (8) step();
      n_checks++; if (HI !== 32'd0 || LO !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_no_write: got %h_%h expected 0_0", HI, LO); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_idle: got %b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_stall();
      test_back_to_back();
      test_madd();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
